// File: rtl/muldiv_ctrl.sv
// RV32M multiply/divide sequencer: single-cycle registered multiply,
// 32-step restoring divide with sign fix-up, and fast paths for x/0 and overflow.
module muldiv_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [4:0]       alu_ctl,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             flush,
    output logic             stall,
    output logic             busy,
    output logic             result_valid,
    output logic [WIDTH-1:0] result
);

    localparam logic [4:0] C_MUL    = 5'b00010;
    localparam logic [4:0] C_MULH   = 5'b00011;
    localparam logic [4:0] C_MULHSU = 5'b00100;
    localparam logic [4:0] C_MULHU  = 5'b00101;
    localparam logic [4:0] C_DIV    = 5'b00110;
    localparam logic [4:0] C_DIVU   = 5'b00111;
    localparam logic [4:0] C_REM    = 5'b01000;
    localparam logic [4:0] C_REMU   = 5'b01001;

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

    state_t                  state_q;
    logic signed [WIDTH-1:0] a_q, b_q;
    logic [4:0]              ctl_q;
    logic [WIDTH-1:0]        rem_q, quo_q, result_q;
    logic [5:0]              cnt_q;

    function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic c);
        return c ? -v : v;
    endfunction

    // Decode of the incoming request
    logic in_mul, in_div, in_rem, in_sgn, in_zero, in_ovf, accept;
    logic [WIDTH-1:0] fast_res;

    always_comb begin
        in_mul   = (alu_ctl == C_MUL) || (alu_ctl == C_MULH) ||
                   (alu_ctl == C_MULHSU) || (alu_ctl == C_MULHU);
        in_div   = (alu_ctl == C_DIV) || (alu_ctl == C_DIVU) ||
                   (alu_ctl == C_REM) || (alu_ctl == C_REMU);
        in_rem   = (alu_ctl == C_REM) || (alu_ctl == C_REMU);
        in_sgn   = (alu_ctl == C_DIV) || (alu_ctl == C_REM);
        in_zero  = (op_b == '0);
        in_ovf   = in_sgn && (op_a == {1'b1, {(WIDTH-1){1'b0}}}) && (op_b == '1);
        accept   = start && (in_mul || in_div) && (state_q == S_IDLE) && !flush && !rst;
        fast_res = '0;
        if (in_zero)
            fast_res = in_rem ? op_a : '1;
        else if (!in_rem)
            fast_res = {1'b1, {(WIDTH-1){1'b0}}};
    end

    // Multiply datapath on latched operands
    logic                      ext_sa, ext_sb;
    logic signed [WIDTH:0]     ext_a, ext_b;
    logic signed [2*WIDTH-1:0] prod;

    always_comb begin
        ext_sa = (ctl_q == C_MULH) || (ctl_q == C_MULHSU);
        ext_sb = (ctl_q == C_MULH);
        ext_a  = {ext_sa & a_q[WIDTH-1], a_q};
        ext_b  = {ext_sb & b_q[WIDTH-1], b_q};
        prod   = (2*WIDTH)'(ext_a) * (2*WIDTH)'(ext_b);
    end

    // Restoring divide step on magnitudes
    logic             div_sgn, neg_q, neg_r, ctl_rem;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH:0]   shifted, trial;

    always_comb begin
        div_sgn = (ctl_q == C_DIV) || (ctl_q == C_REM);
        ctl_rem = (ctl_q == C_REM) || (ctl_q == C_REMU);
        neg_q   = div_sgn && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
        neg_r   = div_sgn && a_q[WIDTH-1];
        dvs     = neg_if(b_q, div_sgn && b_q[WIDTH-1]);
        shifted = {rem_q, quo_q[WIDTH-1]};
        trial   = shifted - {1'b0, dvs};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            ctl_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else if (flush) begin
            state_q <= S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        a_q   <= op_a;
                        b_q   <= op_b;
                        ctl_q <= alu_ctl;
                        if (in_mul) begin
                            state_q <= S_MUL;
                        end else if (in_zero || in_ovf) begin
                            result_q <= fast_res;
                            state_q  <= S_DONE;
                        end else begin
                            rem_q   <= '0;
                            quo_q   <= neg_if(op_a, in_sgn && op_a[WIDTH-1]);
                            cnt_q   <= '0;
                            state_q <= S_DIV;
                        end
                    end
                end
                S_MUL: begin
                    result_q <= (ctl_q == C_MUL) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
                    state_q  <= S_DONE;
                end
                S_DIV: begin
                    if (!trial[WIDTH]) begin
                        rem_q <= trial[WIDTH-1:0];
                        quo_q <= {quo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_q <= shifted[WIDTH-1:0];
                        quo_q <= {quo_q[WIDTH-2:0], 1'b0};
                    end
                    cnt_q <= cnt_q + 6'd1;
                    if (cnt_q == 6'd31)
                        state_q <= S_FIX;
                end
                S_FIX: begin
                    result_q <= ctl_rem ? neg_if(rem_q, neg_r) : neg_if(quo_q, neg_q);
                    state_q  <= S_DONE;
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Stall drops in DONE so the pipeline advances on the result cycle
    always_comb begin
        stall        = !flush && (accept || (state_q == S_MUL) ||
                                  (state_q == S_DIV) || (state_q == S_FIX));
        busy         = (state_q != S_IDLE);
        result_valid = (state_q == S_DONE) && !flush;
        result       = result_q;
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: scoreboard of expected results and latencies,
// checked with immediate assertions.
module tb_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [4:0]  alu_ctl = '0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        flush = 1'b0;
    logic        stall, busy, result_valid;
    logic [31:0] result;

    muldiv_ctrl #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .alu_ctl(alu_ctl),
        .op_a(op_a), .op_b(op_b), .flush(flush),
        .stall(stall), .busy(busy), .result_valid(result_valid), .result(result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   total  = 0;
    int   passed = 0;
    int   failed = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one op in the current cycle and wait (bounded) for its result
    task automatic run_op(input string tag, input logic [4:0] ctl, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int lat);
        exp_t e;
        int   n;
        start   = 1'b1;
        alu_ctl = ctl;
        op_a    = a;
        op_b    = b;
        e.res   = exp_res;
        e.lat   = lat;
        sb.push_back(e);
        #1 chk({tag, "_stall_T"}, {31'd0, stall}, 32'd1);
        tick();
        start   = 1'b0;
        alu_ctl = '0;
        n       = 1;
        if (lat > 1) chk({tag, "_stall_T1"}, {31'd0, stall}, 32'd1);
        while (!result_valid && n < 60) begin
            tick();
            n++;
        end
        e = sb.pop_front();
        chk({tag, "_valid"}, {31'd0, result_valid}, 32'd1);
        chk({tag, "_result"}, result, e.res);
        chk({tag, "_latency"}, n, e.lat);
        chk({tag, "_stall_done"}, {31'd0, stall}, 32'd0);
        tick();
    endtask

    task automatic no_valid(input string tag, input int cycles);
        int v = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (result_valid) v++;
        end
        chk(tag, v, 0);
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_valid", {31'd0, result_valid}, 32'd0);
        chk("rst_result", result, 32'd0);
        tick();

        run_op("mul",    5'b00010, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 2);
        run_op("mulhu",  5'b00101, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 2);
        run_op("mulh",   5'b00011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 2);
        run_op("mulhsu", 5'b00100, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 2);
        run_op("div",    5'b00110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34);
        run_op("rem",    5'b01000, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34);
        run_op("divu",   5'b00111, 32'd100,      32'd7,        32'd14,       34);
        run_op("remu",   5'b01001, 32'd100,      32'd7,        32'd2,        34);
        run_op("div_nd", 5'b00110, 32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 34);
        run_op("rem_nd", 5'b01000, 32'd100,      32'hFFFFFFF9, 32'd2,        34);
        run_op("divu_z", 5'b00111, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
        run_op("rem_z",  5'b01000, 32'd5,        32'd0,        32'd5,        1);
        run_op("div_ov", 5'b00110, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        run_op("rem_ov", 5'b01000, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1);

        // Flush a divide at T+10, then a fresh multiply at T+12
        start = 1'b1; alu_ctl = 5'b00110; op_a = 32'd1000; op_b = 32'd3;
        #1 chk("fl_stall_T", {31'd0, stall}, 32'd1);
        tick();
        start = 1'b0; alu_ctl = '0;
        repeat (9) tick();
        flush = 1'b1;
        #1 chk("fl_stall_flush", {31'd0, stall}, 32'd0);
        tick();
        flush = 1'b0;
        chk("fl_busy_T11", {31'd0, busy}, 32'd0);
        chk("fl_valid_T11", {31'd0, result_valid}, 32'd0);
        tick();
        run_op("fl_mul", 5'b00010, 32'd3, 32'd4, 32'd12, 2);
        no_valid("fl_no_valid", 26);

        // Reset in the middle of a divide
        start = 1'b1; alu_ctl = 5'b00111; op_a = 32'd1000; op_b = 32'd7;
        tick();
        start = 1'b0; alu_ctl = '0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("mr_stall", {31'd0, stall}, 32'd0);
        chk("mr_busy", {31'd0, busy}, 32'd0);
        chk("mr_valid", {31'd0, result_valid}, 32'd0);
        chk("mr_result", result, 32'd0);
        no_valid("mr_no_valid", 40);

        // start held through DONE is not taken again
        begin
            exp_t e;
            start = 1'b1; alu_ctl = 5'b00010; op_a = 32'd2; op_b = 32'd3;
            e.res = 32'd6; e.lat = 2;
            sb.push_back(e);
            tick();
            chk("hold_stall_T1", {31'd0, stall}, 32'd1);
            tick();
            e = sb.pop_front();
            chk("hold_valid", {31'd0, result_valid}, 32'd1);
            chk("hold_result", result, e.res);
            chk("hold_stall_done", {31'd0, stall}, 32'd0);
            tick();
            start = 1'b0; alu_ctl = '0;
            #1 chk("hold_busy_after", {31'd0, busy}, 32'd0);
        end

        // Non-M code is ignored
        tick();
        start = 1'b1; alu_ctl = 5'b00000; op_a = 32'd9; op_b = 32'd9;
        #1 chk("nonm_stall", {31'd0, stall}, 32'd0);
        tick();
        start = 1'b0;
        chk("nonm_busy", {31'd0, busy}, 32'd0);
        chk("sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
